// File: rtl/pipeline_bus_arbiter_if.sv
// Bus arbiter interface: requests from the pipeline/DMA, grants and
// qualifiers back. master = requester side, slave = arbiter side.
interface pipeline_bus_arbiter_if;
   logic       fetch_req;
   logic       exec_req;
   logic       dma_req;
   logic       fetch_grant;
   logic       exec_grant;
   logic       dma_grant;
   logic [1:0] bus_owner;
   logic       access_done;
   logic       fetch_suppress;
   logic       pipe_stall;
   logic       dma_starving;

   modport master (
      output fetch_req, exec_req, dma_req,
      input  fetch_grant, exec_grant, dma_grant, bus_owner,
      input  access_done, fetch_suppress, pipe_stall, dma_starving
   );

   modport slave (
      input  fetch_req, exec_req, dma_req,
      output fetch_grant, exec_grant, dma_grant, bus_owner,
      output access_done, fetch_suppress, pipe_stall, dma_starving
   );
endinterface

// File: rtl/pipeline_bus_arbiter.sv
// Memory bus arbiter for fetch, execute and DMA with wait states,
// DMA bursts and starvation boost. Ports: clock_in, reset (sync, high), bus.
module pipeline_bus_arbiter #(
   parameter int WAIT_STATES   = 1,
   parameter int STARVE_LIMIT  = 8,
   parameter int DMA_BURST_MAX = 4
) (
   input logic                   clock_in,
   input logic                   reset,
   pipeline_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DMA} state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);
   localparam logic [3:0] BM = 4'(DMA_BURST_MAX);
   localparam logic [7:0] SL = 8'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic       exec_sel_q, exec_sel_d;
   logic [3:0] wait_q, wait_d;
   logic [3:0] burst_q, burst_d;
   logic [7:0] starve_q, starve_d;

   logic fg, eg, dg, done, arb, starving;
   logic others, burst_last, dma_ok;

   assign fg = (state_q == ACCESS) & ~exec_sel_q;
   assign eg = (state_q == ACCESS) & exec_sel_q;
   assign dg = (state_q == DMA);

   assign done     = (state_q != IDLE) & (wait_q == WS);
   assign arb      = (state_q == IDLE) | done;
   assign starving = (starve_q == SL);

   // A burst that has used its last slot yields to any pending
   // pipeline request in the same arbitration.
   assign others     = bus.exec_req | bus.fetch_req;
   assign burst_last = dg & ((burst_q + 4'd1) >= BM);
   assign dma_ok     = bus.dma_req & ~(burst_last & others);

   always_comb begin
      state_d    = state_q;
      exec_sel_d = exec_sel_q;
      burst_d    = burst_q;
      wait_d     = (state_q == IDLE) ? 4'd0 : wait_q + 4'd1;
      if (arb) begin
         wait_d  = 4'd0;
         burst_d = 4'd0;
         priority case (1'b1)
            dg && bus.dma_req && !burst_last: begin
               state_d = DMA;
               burst_d = burst_q + 4'd1;
            end
            starving && dma_ok: state_d = DMA;
            bus.exec_req: begin
               state_d    = ACCESS;
               exec_sel_d = 1'b1;
            end
            bus.fetch_req: begin
               state_d    = ACCESS;
               exec_sel_d = 1'b0;
            end
            dma_ok:  state_d = DMA;
            default: state_d = IDLE;
         endcase
      end
   end

   // Cleared on the same edge the DMA grant rises, so the starving flag
   // never overlaps the grant.
   always_comb begin
      starve_d = starve_q;
      if (!bus.dma_req || dg || state_d == DMA)
         starve_d = 8'd0;
      else if (!starving)
         starve_d = starve_q + 8'd1;
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q    <= IDLE;
         exec_sel_q <= 1'b0;
         wait_q     <= 4'd0;
         burst_q    <= 4'd0;
         starve_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         exec_sel_q <= exec_sel_d;
         wait_q     <= wait_d;
         burst_q    <= burst_d;
         starve_q   <= starve_d;
      end
   end

   assign bus.fetch_grant    = fg;
   assign bus.exec_grant     = eg;
   assign bus.dma_grant      = dg;
   assign bus.bus_owner      = {eg | dg, fg | dg};
   assign bus.access_done    = done;
   assign bus.dma_starving   = starving;
   assign bus.fetch_suppress = bus.fetch_req & ~(fg & done);
   assign bus.pipe_stall     = bus.exec_req & ~(eg & done);
endmodule

// File: tb/tb_pipeline_bus_arbiter.sv
// Directed bench for pipeline_bus_arbiter: one DUT with WAIT_STATES=1,
// one with WAIT_STATES=0. Inputs change #1 after posedge, checks #2 after.
module tb_pipeline_bus_arbiter;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   pipeline_bus_arbiter_if ifa ();
   pipeline_bus_arbiter_if ifb ();

   pipeline_bus_arbiter #(
      .WAIT_STATES(1), .STARVE_LIMIT(8), .DMA_BURST_MAX(4)
   ) dut_a (
      .clock_in(clk), .reset(reset), .bus(ifa)
   );

   pipeline_bus_arbiter #(
      .WAIT_STATES(0), .STARVE_LIMIT(8), .DMA_BURST_MAX(4)
   ) dut_b (
      .clock_in(clk), .reset(reset), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifa.fetch_req = 1'b0;
      ifa.exec_req  = 1'b0;
      ifa.dma_req   = 1'b0;
      ifb.fetch_req = 1'b0;
      ifb.exec_req  = 1'b0;
      ifb.dma_req   = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      do_reset();
      #1;
      got = {ifa.fetch_grant, ifa.exec_grant, ifa.dma_grant,
             ifa.bus_owner, ifa.access_done, ifa.dma_starving, 1'b0};
      n_cmp++;
      if (got !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_a: got %b want 00000000", got);
      end
      got = {ifb.fetch_grant, ifb.exec_grant, ifb.dma_grant,
             ifb.bus_owner, ifb.access_done, ifb.dma_starving, 1'b0};
      n_cmp++;
      if (got !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_b: got %b want 00000000", got);
      end
   endtask

   // {fetch_grant, access_done, fetch_suppress, bus_owner}
   task automatic test_fetch();
      logic [4:0] got, exp;
      do_reset();
      for (int c = 0; c <= 2; c++) begin
         if (c > 0) tick();
         ifa.fetch_req = 1'b1;
         #1;
         got = {ifa.fetch_grant, ifa.access_done, ifa.fetch_suppress,
                ifa.bus_owner};
         exp = {c >= 1, c == 2, c < 2, (c >= 1) ? 2'b01 : 2'b00};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL fetch c%0d: got %b want %b", c, got, exp);
         end
      end
   endtask

   // {exec_grant, fetch_grant, pipe_stall, fetch_suppress, bus_owner}
   task automatic test_priority();
      logic [5:0] got, exp;
      logic       e, f;
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) tick();
         ifa.exec_req  = (c <= 1);
         ifa.fetch_req = (c <= 3);
         #1;
         e   = (c == 1 || c == 2);
         f   = (c == 3 || c == 4);
         got = {ifa.exec_grant, ifa.fetch_grant, ifa.pipe_stall,
                ifa.fetch_suppress, ifa.bus_owner};
         exp = {e, f, c < 2, c <= 3, e ? 2'b10 : f ? 2'b01 : 2'b00};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL priority c%0d: got %b want %b", c, got, exp);
         end
         n_cmp++;
         if ($countones({ifa.fetch_grant, ifa.exec_grant,
                         ifa.dma_grant}) > 1) begin
            n_bad++;
            $display("FAIL onehot c%0d: got %b want at most one",
                     c, {ifa.fetch_grant, ifa.exec_grant, ifa.dma_grant});
         end
      end
   endtask

   // {dma_grant, dma_starving, bus_owner}
   task automatic test_starve();
      logic [3:0] got, exp;
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         if (c > 0) tick();
         ifa.exec_req  = 1'b1;
         ifa.fetch_req = 1'b1;
         ifa.dma_req   = 1'b1;
         #1;
         got = {ifa.dma_grant, ifa.dma_starving, ifa.bus_owner};
         exp = {c == 9, c == 8,
                (c == 0) ? 2'b00 : (c == 9) ? 2'b11 : 2'b10};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL starve c%0d: got %b want %b", c, got, exp);
         end
      end
   endtask

   // {dma_grant, fetch_grant, access_done, bus_owner}
   task automatic test_dma_burst();
      logic [4:0] got, exp;
      logic       d, f;
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         if (c > 0) tick();
         ifa.dma_req   = 1'b1;
         ifa.fetch_req = (c >= 3);
         #1;
         d   = (c >= 1 && c <= 8);
         f   = (c == 9);
         got = {ifa.dma_grant, ifa.fetch_grant, ifa.access_done,
                ifa.bus_owner};
         exp = {d, f, c >= 2 && c <= 8 && (c % 2) == 0,
                d ? 2'b11 : f ? 2'b01 : 2'b00};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL dma_burst c%0d: got %b want %b", c, got, exp);
         end
      end
   endtask

   // {exec_grant, access_done, bus_owner}
   task automatic test_reset_mid();
      logic [3:0] got, exp;
      logic       e;
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) tick();
         ifa.exec_req = 1'b1;
         reset        = (c == 1);
         #1;
         e   = (c == 1 || c == 3 || c == 4);
         got = {ifa.exec_grant, ifa.access_done, ifa.bus_owner};
         exp = {e, c == 4, e ? 2'b10 : 2'b00};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_mid c%0d: got %b want %b", c, got, exp);
         end
      end
      reset = 1'b0;
   endtask

   // {fetch_grant, access_done, fetch_suppress} with WAIT_STATES=0
   task automatic test_back_to_back();
      logic [2:0] got, exp;
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) tick();
         ifb.fetch_req = 1'b1;
         #1;
         got = {ifb.fetch_grant, ifb.access_done, ifb.fetch_suppress};
         exp = {c >= 1, c >= 1, c == 0};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL back_to_back c%0d: got %b want %b",
                     c, got, exp);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_priority();
      test_starve();
      test_dma_burst();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
